// File: rtl/pipeline_tracker.sv
// rtl/pipeline_tracker.sv - per-stage valid/hazard-metadata tracker with saturating perf counters
module pipeline_tracker #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_is_branch,
  input  logic [4:0]           id_regw_addr,
  input  logic                 id_wb_wen,
  input  logic                 if_rst,
  input  logic                 id_rst,
  input  logic                 exe_rst,
  input  logic                 mem_rst,
  input  logic                 wb_rst,
  input  logic                 if_en,
  input  logic                 id_en,
  input  logic                 exe_en,
  input  logic                 mem_en,
  input  logic                 wb_en,
  output logic                 if_valid,
  output logic                 id_valid,
  output logic                 exe_valid,
  output logic                 mem_valid,
  output logic                 wb_valid,
  output logic                 is_branch_exe,
  output logic [4:0]           regw_addr_exe,
  output logic                 wb_wen_exe,
  output logic                 is_branch_mem,
  output logic [4:0]           regw_addr_mem,
  output logic                 wb_wen_mem,
  output logic [4:0]           regw_addr_wb,
  output logic                 wb_wen_wb,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] retire_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Counters stick at all-ones so a long debug session never wraps to a small value.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic inc);
    return (inc && (v != CNT_MAX)) ? v + CNT_ONE : v;
  endfunction

  logic                 if_valid_q, if_valid_d;
  logic                 id_valid_q, id_valid_d;
  logic                 exe_valid_q, exe_valid_d;
  logic                 exe_branch_q, exe_branch_d;
  logic [4:0]           exe_addr_q, exe_addr_d;
  logic                 exe_wen_q, exe_wen_d;
  logic                 mem_valid_q, mem_valid_d;
  logic                 mem_branch_q, mem_branch_d;
  logic [4:0]           mem_addr_q, mem_addr_d;
  logic                 mem_wen_q, mem_wen_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [4:0]           wb_addr_q, wb_addr_d;
  logic                 wb_wen_q, wb_wen_d;
  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  // IF: once loaded the fetch stage always holds a real instruction.
  always_comb begin
    if_valid_d = if_valid_q;
    if (if_rst) begin
      if_valid_d = 1'b0;
    end else if (if_en) begin
      if_valid_d = 1'b1;
    end
  end

  // ID: inherits validity from IF; a held ID keeps its flag through an EXE bubble.
  always_comb begin
    id_valid_d = id_valid_q;
    if (id_rst) begin
      id_valid_d = 1'b0;
    end else if (id_en) begin
      id_valid_d = if_valid_q;
    end
  end

  // EXE: capture decoded metadata, masked so a bubble never carries a hazard.
  always_comb begin
    exe_valid_d  = exe_valid_q;
    exe_branch_d = exe_branch_q;
    exe_addr_d   = exe_addr_q;
    exe_wen_d    = exe_wen_q;
    if (exe_rst) begin
      exe_valid_d  = 1'b0;
      exe_branch_d = 1'b0;
      exe_addr_d   = 5'd0;
      exe_wen_d    = 1'b0;
    end else if (exe_en) begin
      exe_valid_d  = id_valid_q;
      exe_branch_d = id_is_branch & id_valid_q;
      exe_addr_d   = id_valid_q ? id_regw_addr : 5'd0;
      exe_wen_d    = id_wb_wen & id_valid_q;
    end
  end

  // MEM: straight copy of the EXE fields.
  always_comb begin
    mem_valid_d  = mem_valid_q;
    mem_branch_d = mem_branch_q;
    mem_addr_d   = mem_addr_q;
    mem_wen_d    = mem_wen_q;
    if (mem_rst) begin
      mem_valid_d  = 1'b0;
      mem_branch_d = 1'b0;
      mem_addr_d   = 5'd0;
      mem_wen_d    = 1'b0;
    end else if (mem_en) begin
      mem_valid_d  = exe_valid_q;
      mem_branch_d = exe_branch_q;
      mem_addr_d   = exe_addr_q;
      mem_wen_d    = exe_wen_q;
    end
  end

  // WB: copy of MEM minus the branch flag, which nothing downstream needs.
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_wen_d   = wb_wen_q;
    if (wb_rst) begin
      wb_valid_d = 1'b0;
      wb_addr_d  = 5'd0;
      wb_wen_d   = 1'b0;
    end else if (wb_en) begin
      wb_valid_d = mem_valid_q;
      wb_addr_d  = mem_addr_q;
      wb_wen_d   = mem_wen_q;
    end
  end

  // Performance counters: each condition is independent and may fire in the same cycle.
  always_comb begin
    cycle_cnt_d  = sat_inc(cycle_cnt_q, wb_en);
    retire_cnt_d = sat_inc(retire_cnt_q, wb_en & wb_valid_q);
    stall_cnt_d  = sat_inc(stall_cnt_q, exe_rst & ~id_en);
    flush_cnt_d  = sat_inc(flush_cnt_q, id_rst & id_en);
  end

  // State register: global reset overrides every stage reset and enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_q   <= 1'b0;
      id_valid_q   <= 1'b0;
      exe_valid_q  <= 1'b0;
      exe_branch_q <= 1'b0;
      exe_addr_q   <= 5'd0;
      exe_wen_q    <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_branch_q <= 1'b0;
      mem_addr_q   <= 5'd0;
      mem_wen_q    <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= 5'd0;
      wb_wen_q     <= 1'b0;
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if_valid_q   <= if_valid_d;
      id_valid_q   <= id_valid_d;
      exe_valid_q  <= exe_valid_d;
      exe_branch_q <= exe_branch_d;
      exe_addr_q   <= exe_addr_d;
      exe_wen_q    <= exe_wen_d;
      mem_valid_q  <= mem_valid_d;
      mem_branch_q <= mem_branch_d;
      mem_addr_q   <= mem_addr_d;
      mem_wen_q    <= mem_wen_d;
      wb_valid_q   <= wb_valid_d;
      wb_addr_q    <= wb_addr_d;
      wb_wen_q     <= wb_wen_d;
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign if_valid      = if_valid_q;
  assign id_valid      = id_valid_q;
  assign exe_valid     = exe_valid_q;
  assign mem_valid     = mem_valid_q;
  assign wb_valid      = wb_valid_q;
  assign is_branch_exe = exe_branch_q;
  assign regw_addr_exe = exe_addr_q;
  assign wb_wen_exe    = exe_wen_q;
  assign is_branch_mem = mem_branch_q;
  assign regw_addr_mem = mem_addr_q;
  assign wb_wen_mem    = mem_wen_q;
  assign regw_addr_wb  = wb_addr_q;
  assign wb_wen_wb     = wb_wen_q;
  assign cycle_cnt     = cycle_cnt_q;
  assign retire_cnt    = retire_cnt_q;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_tracker.sv
// tb/tb_pipeline_tracker.sv - scoreboard bench for pipeline_tracker
module tb_pipeline_tracker;

  typedef struct packed {
    logic [4:0]  v;
    logic [19:0] fb;
    logic [31:0] cyc;
    logic [31:0] ret;
    logic [31:0] stl;
    logic [31:0] fl;
  } snap_t;

  logic clk;
  logic rst;
  logic id_is_branch;
  logic [4:0] id_regw_addr;
  logic id_wb_wen;
  logic if_rst, id_rst, exe_rst, mem_rst, wb_rst;
  logic if_en, id_en, exe_en, mem_en, wb_en;
  logic if_valid, id_valid, exe_valid, mem_valid, wb_valid;
  logic is_branch_exe, wb_wen_exe, is_branch_mem, wb_wen_mem, wb_wen_wb;
  logic [4:0] regw_addr_exe, regw_addr_mem, regw_addr_wb;
  logic [31:0] cycle_cnt, retire_cnt, stall_cnt, flush_cnt;

  logic rst4;
  logic en4;
  logic v4_if, v4_id, v4_exe, v4_mem, v4_wb;
  logic b4_exe, w4_exe, b4_mem, w4_mem, w4_wb;
  logic [4:0] a4_exe, a4_mem, a4_wb;
  logic [3:0] cyc4, ret4, stl4, fl4;

  int n_checks = 0;
  int n_fail = 0;
  snap_t sb[$];

  logic m_if, m_id, m_ex, m_mem, m_wb;
  logic m_exb, m_exw, m_mb, m_mw, m_ww;
  logic [4:0] m_exa, m_ma, m_wa;
  logic [31:0] m_cyc, m_ret, m_stl, m_fl;

  pipeline_tracker #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .id_is_branch(id_is_branch), .id_regw_addr(id_regw_addr), .id_wb_wen(id_wb_wen),
    .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
    .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
    .if_valid(if_valid), .id_valid(id_valid), .exe_valid(exe_valid),
    .mem_valid(mem_valid), .wb_valid(wb_valid),
    .is_branch_exe(is_branch_exe), .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe),
    .is_branch_mem(is_branch_mem), .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem),
    .regw_addr_wb(regw_addr_wb), .wb_wen_wb(wb_wen_wb),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_tracker #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4),
    .id_is_branch(1'b0), .id_regw_addr(5'd9), .id_wb_wen(1'b1),
    .if_rst(1'b0), .id_rst(1'b0), .exe_rst(1'b0), .mem_rst(1'b0), .wb_rst(1'b0),
    .if_en(en4), .id_en(en4), .exe_en(en4), .mem_en(en4), .wb_en(en4),
    .if_valid(v4_if), .id_valid(v4_id), .exe_valid(v4_exe),
    .mem_valid(v4_mem), .wb_valid(v4_wb),
    .is_branch_exe(b4_exe), .regw_addr_exe(a4_exe), .wb_wen_exe(w4_exe),
    .is_branch_mem(b4_mem), .regw_addr_mem(a4_mem), .wb_wen_mem(w4_mem),
    .regw_addr_wb(a4_wb), .wb_wen_wb(w4_wb),
    .cycle_cnt(cyc4), .retire_cnt(ret4), .stall_cnt(stl4), .flush_cnt(fl4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic snap_t dut_snap();
    snap_t s;
    s.v   = {wb_valid, mem_valid, exe_valid, id_valid, if_valid};
    s.fb  = {is_branch_exe, regw_addr_exe, wb_wen_exe, is_branch_mem, regw_addr_mem,
             wb_wen_mem, regw_addr_wb, wb_wen_wb};
    s.cyc = cycle_cnt;
    s.ret = retire_cnt;
    s.stl = stall_cnt;
    s.fl  = flush_cnt;
    return s;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.v   = {m_wb, m_mem, m_ex, m_id, m_if};
    s.fb  = {m_exb, m_exa, m_exw, m_mb, m_ma, m_mw, m_wa, m_ww};
    s.cyc = m_cyc;
    s.ret = m_ret;
    s.stl = m_stl;
    s.fl  = m_fl;
    return s;
  endfunction

  // Reference: evaluate stages back-to-front so each reads its predecessor's pre-edge value.
  task automatic model_advance();
    if (rst) begin
      {m_if, m_id, m_ex, m_mem, m_wb} = '0;
      {m_exb, m_exw, m_mb, m_mw, m_ww} = '0;
      {m_exa, m_ma, m_wa} = '0;
      {m_cyc, m_ret, m_stl, m_fl} = '0;
    end else begin
      if (wb_en && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      if (wb_en && m_wb && m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
      if (exe_rst && !id_en && m_stl != 32'hFFFF_FFFF) m_stl = m_stl + 1;
      if (id_rst && id_en && m_fl != 32'hFFFF_FFFF) m_fl = m_fl + 1;
      if (wb_rst) begin m_wb = 0; m_wa = 0; m_ww = 0; end
      else if (wb_en) begin m_wb = m_mem; m_wa = m_ma; m_ww = m_mw; end
      if (mem_rst) begin m_mem = 0; m_mb = 0; m_ma = 0; m_mw = 0; end
      else if (mem_en) begin m_mem = m_ex; m_mb = m_exb; m_ma = m_exa; m_mw = m_exw; end
      if (exe_rst) begin m_ex = 0; m_exb = 0; m_exa = 0; m_exw = 0; end
      else if (exe_en) begin
        m_ex  = m_id;
        m_exb = id_is_branch && m_id;
        m_exw = id_wb_wen && m_id;
        m_exa = m_id ? id_regw_addr : 5'd0;
      end
      if (id_rst) m_id = 0;
      else if (id_en) m_id = m_if;
      if (if_rst) m_if = 0;
      else if (if_en) m_if = 1;
    end
  endtask

  // One clock: push the model's prediction, let the edge pass, pop and compare.
  task automatic step();
    snap_t e, a;
    model_advance();
    sb.push_back(model_snap());
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      a = dut_snap();
      check("sb_valids", {27'd0, a.v}, {27'd0, e.v});
      check("sb_feedback", {12'd0, a.fb}, {12'd0, e.fb});
      check("sb_cycle_cnt", a.cyc, e.cyc);
      check("sb_retire_cnt", a.ret, e.ret);
      check("sb_stall_cnt", a.stl, e.stl);
      check("sb_flush_cnt", a.fl, e.fl);
    end
  endtask

  task automatic set_en(input logic [4:0] e);
    {wb_en, mem_en, exe_en, id_en, if_en} = e;
  endtask

  task automatic set_srst(input logic [4:0] r);
    {wb_rst, mem_rst, exe_rst, id_rst, if_rst} = r;
  endtask

  initial begin
    snap_t f;
    logic [31:0] ret_b;
    logic id_b;
    {m_if, m_id, m_ex, m_mem, m_wb} = '0;
    {m_exb, m_exw, m_mb, m_mw, m_ww} = '0;
    {m_exa, m_ma, m_wa} = '0;
    {m_cyc, m_ret, m_stl, m_fl} = '0;
    rst = 1'b1; rst4 = 1'b1; en4 = 1'b1;
    id_is_branch = 1'b0; id_regw_addr = 5'd5; id_wb_wen = 1'b1;
    set_srst(5'b00000); set_en(5'b11111);

    // Power-up reset then refill.
    step();
    f = dut_snap();
    check("reset_all_zero", {27'd0, f.v} | {12'd0, f.fb} | f.cyc | f.ret | f.stl | f.fl, 32'd0);
    step();
    rst = 1'b0;
    step();
    check("fill_if_valid_e1", {31'd0, if_valid}, 32'd1);
    check("fill_id_valid_e1", {31'd0, id_valid}, 32'd0);
    repeat (3) step();
    check("fill_wb_valid_e4", {31'd0, wb_valid}, 32'd0);
    step();
    check("fill_wb_valid_e5", {31'd0, wb_valid}, 32'd1);
    check("fill_addr_wb_e5", {27'd0, regw_addr_wb}, 32'd5);
    step();
    check("fill_retire_e6", retire_cnt, 32'd1);

    // Steady flow with varied decode data.
    for (int i = 0; i < 8; i++) begin
      id_regw_addr = 5'($urandom_range(0, 31));
      id_wb_wen = 1'($urandom_range(0, 1));
      step();
    end

    // Register-hazard stall: EXE bubble, IF/ID held.
    id_regw_addr = 5'd7; id_wb_wen = 1'b1;
    id_b = m_id;
    exe_rst = 1'b1; if_en = 1'b0; id_en = 1'b0;
    step();
    check("stall_exe_valid", {31'd0, exe_valid}, 32'd0);
    check("stall_wen_exe", {31'd0, wb_wen_exe}, 32'd0);
    check("stall_addr_exe", {27'd0, regw_addr_exe}, 32'd0);
    check("stall_id_held", {31'd0, id_valid}, {31'd0, id_b});
    check("stall_cnt_one", stall_cnt, 32'd1);
    exe_rst = 1'b0; if_en = 1'b1; id_en = 1'b1;
    step();
    step();
    check("stall_bubble_at_wb", {31'd0, wb_valid}, 32'd0);
    ret_b = retire_cnt;
    step();
    check("stall_retire_skip", retire_cnt, ret_b);
    step();

    // Branch captured into EXE, then a three-cycle ID flush.
    id_is_branch = 1'b1;
    step();
    check("br_exe", {31'd0, is_branch_exe}, 32'd1);
    id_is_branch = 1'b0; id_rst = 1'b1;
    step();
    check("br_mem", {31'd0, is_branch_mem}, 32'd1);
    check("flush_id_valid_1", {31'd0, id_valid}, 32'd0);
    step();
    check("flush_id_valid_2", {31'd0, id_valid}, 32'd0);
    step();
    check("flush_id_valid_3", {31'd0, id_valid}, 32'd0);
    check("flush_cnt_three", flush_cnt, 32'd3);
    id_rst = 1'b0;
    repeat (6) step();

    // Debug freeze: everything held for ten cycles, then resume.
    f = model_snap();
    set_en(5'b00000);
    id_regw_addr = 5'd21;
    repeat (10) step();
    check("freeze_valids", {27'd0, dut_snap().v}, {27'd0, f.v});
    check("freeze_feedback", {12'd0, dut_snap().fb}, {12'd0, f.fb});
    check("freeze_cycle_cnt", cycle_cnt, f.cyc);
    check("freeze_retire_cnt", retire_cnt, f.ret);
    set_en(5'b11111);
    step();
    check("resume_cycle_cnt", cycle_cnt, f.cyc + 32'd1);
    id_regw_addr = 5'd5; id_wb_wen = 1'b1;
    repeat (5) step();

    // Reset mid-operation with a full pipe, then identical refill.
    check("full_before_rst", {27'd0, dut_snap().v}, 32'h1F);
    rst = 1'b1;
    step();
    f = dut_snap();
    check("midrst_valids", {27'd0, f.v}, 32'd0);
    check("midrst_feedback", {12'd0, f.fb}, 32'd0);
    check("midrst_counters", f.cyc | f.ret | f.stl | f.fl, 32'd0);
    rst = 1'b0;
    step();
    check("refill_valids_e1", {27'd0, dut_snap().v}, 32'h01);
    repeat (4) step();
    check("refill_valids_e5", {27'd0, dut_snap().v}, 32'h1F);
    check("refill_addr_wb_e5", {27'd0, regw_addr_wb}, 32'd5);

    // 4-bit counters: saturate at 15 and hold.
    rst4 = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      step();
      check("sat_cycle_cnt", {28'd0, cyc4}, (n > 15) ? 32'd15 : 32'(n));
      check("sat_retire_cnt", {28'd0, ret4}, (n < 6) ? 32'd0 : ((n - 5 > 15) ? 32'd15 : 32'(n - 5)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
